cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order extension. Each of the NRALUOP functional units, one per reservation station, hands its completed result (RS tag + value) to a one-entry holding slot in this block. A round-robin arbiter selects one occupied slot per cycle and drives a registered CDB broadcast. The reservation stations use that broadcast for operand wake-up and the RAT uses it for tag retirement.

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-in / broadcast-out bundle for the common-data-bus arbiter.
// The master side is the FU/consumer complex; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int BITWIDTH = 32,
  parameter int NRALUOP  = 8,
  parameter int RS_DEPTH = 8,
  parameter int TAGW     = $clog2(NRALUOP) + $clog2(RS_DEPTH)
);
  localparam int SRCW = $clog2(NRALUOP);
  localparam int CNTW = $clog2(NRALUOP + 1);

  logic [NRALUOP-1:0]               req_valid;
  logic [NRALUOP-1:0][TAGW-1:0]     req_tag;
  logic [NRALUOP-1:0][BITWIDTH-1:0] req_data;
  logic [NRALUOP-1:0]               req_ready;
  logic                             cdb_valid;
  logic [TAGW-1:0]                  cdb_tag;
  logic [BITWIDTH-1:0]              cdb_data;
  logic [SRCW-1:0]                  cdb_src;
  logic [CNTW-1:0]                  pending_cnt;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, pending_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, round-robin pick over occupied slots,
// registered single-result broadcast with no backpressure.
module cdb_slot #(
  parameter int TAGW     = 6,
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [TAGW-1:0]     in_tag,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                grant,
  output logic                ready,
  output logic                valid,
  output logic [TAGW-1:0]     tag,
  output logic [BITWIDTH-1:0] data
);
  // A slot being granted this cycle frees up in time to take a new result.
  assign ready = !rst && !flush && (!valid || grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (in_valid && ready) begin
      valid <= 1'b1;
      tag   <= in_tag;
      data  <= in_data;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int BITWIDTH = 32,
  parameter int NRALUOP  = 8,
  parameter int RS_DEPTH = 8,
  parameter int TAGW     = $clog2(NRALUOP) + $clog2(RS_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int SRCW = $clog2(NRALUOP);
  localparam int CNTW = $clog2(NRALUOP + 1);

  typedef struct packed {
    logic [TAGW-1:0]     tag;
    logic [BITWIDTH-1:0] data;
    logic [SRCW-1:0]     src;
  } cdb_t;

  logic [NRALUOP-1:0]               slot_valid;
  logic [NRALUOP-1:0][TAGW-1:0]     slot_tag;
  logic [NRALUOP-1:0][BITWIDTH-1:0] slot_data;
  logic [NRALUOP-1:0]               slot_ready;
  logic [NRALUOP-1:0]               grant;

  logic [SRCW-1:0] rr_ptr;
  logic [SRCW-1:0] scan_idx;
  logic [SRCW-1:0] gnt_idx;
  logic            gnt_any;
  logic            gnt_ok;
  logic [CNTW-1:0] cnt;

  logic            cdb_valid_q;
  cdb_t            cdb_q;

  for (genvar i = 0; i < NRALUOP; i++) begin : g_slot
    cdb_slot #(.TAGW(TAGW), .BITWIDTH(BITWIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (bus.req_valid[i]),
      .in_tag   (bus.req_tag[i]),
      .in_data  (bus.req_data[i]),
      .grant    (grant[i]),
      .ready    (slot_ready[i]),
      .valid    (slot_valid[i]),
      .tag      (slot_tag[i]),
      .data     (slot_data[i])
    );
  end

  // Scan from rr_ptr upward; NRALUOP is a power of two so the index wraps for free.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NRALUOP; k++) begin
      scan_idx = rr_ptr + SRCW'(k);
      if (!gnt_any && slot_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign gnt_ok = gnt_any && !flush && !rst;

  always_comb begin
    grant = '0;
    if (gnt_ok) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NRALUOP; i++) cnt = cnt + CNTW'(slot_valid[i]);
  end

  // Payload holds when idle so consumers never see a glitching tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      rr_ptr      <= '0;
    end else begin
      cdb_valid_q <= gnt_ok;
      if (gnt_ok) begin
        cdb_q.tag  <= slot_tag[gnt_idx];
        cdb_q.data <= slot_data[gnt_idx];
        cdb_q.src  <= gnt_idx;
        rr_ptr     <= gnt_idx + SRCW'(1);
      end
    end
  end

  assign bus.req_ready   = slot_ready;
  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_tag     = cdb_q.tag;
  assign bus.cdb_data    = cdb_q.data;
  assign bus.cdb_src     = cdb_q.src;
  assign bus.pending_cnt = cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: scoreboard of expected broadcasts checked
// every cycle, plus point checks of ready/pending/valid at key cycles.
module tb_cdb_arbiter;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int TW = 6;

  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
    logic [2:0]    src;
  } exp_t;

  logic clk;
  logic rst;
  logic flush;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  cdb_arbiter_if #(.BITWIDTH(W), .NRALUOP(N), .RS_DEPTH(8), .TAGW(TW)) bus ();

  cdb_arbiter #(.BITWIDTH(W), .NRALUOP(N), .RS_DEPTH(8), .TAGW(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [W-1:0] d, input logic [2:0] s);
    exp_t e;
    e.tag = t; e.data = d; e.src = s;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [W-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_tag[i]   = t;
    bus.req_data[i]  = d;
  endtask

  task automatic clear_req();
    bus.req_valid = '0;
  endtask

  // Advance one cycle, then score any broadcast against the queue head.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.cdb_valid) begin
      check("cdb_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("cdb_tag",  64'(bus.cdb_tag),  64'(e.tag));
        check("cdb_data", 64'(bus.cdb_data), 64'(e.data));
        check("cdb_src",  64'(bus.cdb_src),  64'(e.src));
      end
    end
  endtask

  initial begin
    int n1, n6;
    bit a1, a6;
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = '0; bus.req_tag = '0; bus.req_data = '0;

    // Reset state
    tick(); tick();
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_tag",   64'(bus.cdb_tag),   64'd0);
    check("rst_cdb_data",  64'(bus.cdb_data),  64'd0);
    check("rst_cdb_src",   64'(bus.cdb_src),   64'd0);
    check("rst_pending",   64'(bus.pending_cnt), 64'd0);
    check("rst_ready",     64'(bus.req_ready), 64'd0);
    rst = 1'b0; #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'hFF);

    // Single result from FU3, 2-cycle latency
    set_req(3, 6'h1A, 32'hDEADBEEF); push(6'h1A, 32'hDEADBEEF, 3'd3);
    tick(); clear_req();
    check("t1_pending1", 64'(bus.pending_cnt), 64'd1);
    check("t1_valid_n1", 64'(bus.cdb_valid), 64'd0);
    tick();
    check("t1_valid_n2", 64'(bus.cdb_valid), 64'd1);
    check("t1_pending0", 64'(bus.pending_cnt), 64'd0);
    tick();
    check("t1_valid_n3", 64'(bus.cdb_valid), 64'd0);

    // Full contention from rr_ptr = 0
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_req(i, 6'(i * 9), 32'h100 + 32'(i)); push(6'(i * 9), 32'h100 + 32'(i), 3'(i));
    end
    tick(); clear_req();
    for (int k = 0; k < N; k++) begin
      check("t2_pending", 64'(bus.pending_cnt), 64'(N - k));
      check("t2_ready",   64'(bus.req_ready),   64'(8'hFF >> (7 - k)));
      tick();
    end
    check("t2_pending_end", 64'(bus.pending_cnt), 64'd0);
    tick();
    check("t2_idle", 64'(bus.cdb_valid), 64'd0);

    // Streaming FU5, one result per cycle with no bubbles
    for (int j = 0; j < 10; j++) begin
      set_req(5, 6'(40 + j), 32'h500 + 32'(j)); push(6'(40 + j), 32'h500 + 32'(j), 3'd5);
      check("t3_ready5", 64'(bus.req_ready[5]), 64'd1);
      tick();
      if (j >= 1) check("t3_no_bubble", 64'(bus.cdb_valid), 64'd1);
    end
    clear_req();
    tick();
    check("t3_last", 64'(bus.cdb_valid), 64'd1);
    tick();
    check("t3_idle", 64'(bus.cdb_valid), 64'd0);

    // Fairness: park rr_ptr at 2 via a lone FU1 grant, then keep FU1 and FU6 busy
    set_req(1, 6'd8, 32'hFF); push(6'd8, 32'hFF, 3'd1);
    tick(); clear_req(); tick(); tick();
    n1 = 0; n6 = 0;
    set_req(1, 6'd8, 32'h10); set_req(6, 6'd48, 32'h60);
    for (int k = 0; k < 9; k++) begin
      if (k % 2 == 0) push(6'(48 + k / 2), 32'h60 + 32'(k / 2), 3'd6);
      else            push(6'(8 + k / 2),  32'h10 + 32'(k / 2), 3'd1);
    end
    for (int c = 0; c < 8; c++) begin
      a6 = (c == 0) || (c % 2 == 1);
      a1 = (c % 2 == 0);
      check("t4_ready6", 64'(bus.req_ready[6]), 64'(a6));
      check("t4_ready1", 64'(bus.req_ready[1]), 64'(a1));
      tick();
      if (a6) begin n6++; set_req(6, 6'(48 + n6), 32'h60 + 32'(n6)); end
      if (a1) begin n1++; set_req(1, 6'(8 + n1),  32'h10 + 32'(n1)); end
    end
    clear_req();
    tick(); tick(); tick();
    check("t4_drained", 64'(sb.size()), 64'd0);

    // Flush with four slots occupied and slot 7 about to win (rr_ptr = 7)
    set_req(0, 6'h01, 32'hC0); set_req(2, 6'h02, 32'hC2);
    set_req(4, 6'h04, 32'hC4); set_req(7, 6'h07, 32'hC7);
    tick(); clear_req();
    check("t5_pending4", 64'(bus.pending_cnt), 64'd4);
    check("t5_ready_pre", 64'(bus.req_ready), 64'hEA);
    flush = 1'b1; #1;
    check("t5_ready_flush", 64'(bus.req_ready), 64'd0);
    tick(); flush = 1'b0;
    check("t5_valid", 64'(bus.cdb_valid), 64'd0);
    check("t5_pending0", 64'(bus.pending_cnt), 64'd0);
    set_req(2, 6'h22, 32'hF1F1); push(6'h22, 32'hF1F1, 3'd2);
    tick(); clear_req(); tick();
    check("t5_post_valid", 64'(bus.cdb_valid), 64'd1);
    tick();

    // Reset mid-operation with six pending, then contention must start at 0
    for (int i = 0; i < 6; i++) set_req(i, 6'(16 + i), 32'hBAD0 + 32'(i));
    tick(); clear_req();
    check("t6_pending6", 64'(bus.pending_cnt), 64'd6);
    rst = 1'b1; #1;
    check("t6_ready_rst", 64'(bus.req_ready), 64'd0);
    tick();
    check("t6_valid_rst", 64'(bus.cdb_valid), 64'd0);
    check("t6_ready_rst2", 64'(bus.req_ready), 64'd0);
    tick();
    check("t6_valid_rst2", 64'(bus.cdb_valid), 64'd0);
    rst = 1'b0; #1;
    check("t6_pending0", 64'(bus.pending_cnt), 64'd0);
    check("t6_ready_up", 64'(bus.req_ready), 64'hFF);
    for (int i = 0; i < N; i++) begin
      set_req(i, 6'(i * 7), 32'hA00 + 32'(i)); push(6'(i * 7), 32'hA00 + 32'(i), 3'(i));
    end
    tick(); clear_req();
    for (int k = 0; k < 9; k++) tick();
    check("t6_drained", 64'(sb.size()), 64'd0);
    check("t6_idle", 64'(bus.cdb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
